// File: rtl/window_loader.sv
`default_nettype none
// ============================================================================
//  Module      : window_loader
//  Description : Captures eight serial pixel bytes into a tap window (FILL),
//                then walks a byte-selector index over the taps (SWEEP).
//                Only DW=8 is supported; the taps feed an 8:1 byte selector.
//                Optional macro WINDOW_LOADER_RELU_EN clamps negative
//                (two's complement) bytes to zero as they are stored.
//  Revision    : 1.0 - initial release
// ============================================================================
module window_loader #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic [DW-1:0] tap0,
    output logic [DW-1:0] tap1,
    output logic [DW-1:0] tap2,
    output logic [DW-1:0] tap3,
    output logic [DW-1:0] tap4,
    output logic [DW-1:0] tap5,
    output logic [DW-1:0] tap6,
    output logic [DW-1:0] tap7,
    output logic [2:0]    sel,
    output logic          sel_valid,
    input  logic          sel_ready,
    output logic          win_done,
    output logic [3:0]    fill_count
);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    localparam logic [3:0] c_LAST_FILL = 4'd7;
    localparam logic [2:0] c_LAST_SEL  = 3'd7;

    state_t          r_state;
    logic [DW-1:0]   r_tap [8];
    logic [3:0]      r_fill_count;
    logic [2:0]      r_sel;
    logic            r_sel_valid;
    logic            r_in_ready;
    logic            r_win_done;
    logic [DW-1:0]   w_store;

    // Value written into a tap; optional clamp of negative bytes to zero
`ifdef WINDOW_LOADER_RELU_EN
    always_comb begin
        w_store = in_data[DW-1] ? '0 : in_data;
    end
`else
    always_comb begin
        w_store = in_data;
    end
`endif

    // Window FSM: fill the taps, then sweep the selector; flush/reset restart
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_fill_count <= 4'd0;
            r_sel        <= 3'd0;
            r_sel_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_win_done   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_tap[i] <= '0;
            end
        end else if (flush) begin
            // Taps are intentionally left alone; any concurrent byte is dropped
            r_state      <= ST_FILL;
            r_fill_count <= 4'd0;
            r_sel        <= 3'd0;
            r_sel_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_win_done   <= 1'b0;
        end else begin
            r_win_done <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    if (in_valid) begin
                        r_tap[r_fill_count[2:0]] <= w_store;
                        r_fill_count             <= r_fill_count + 4'd1;
                        if (r_fill_count == c_LAST_FILL) begin
                            r_state     <= ST_SWEEP;
                            r_sel       <= 3'd0;
                            r_sel_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                        end
                    end
                end
                ST_SWEEP: begin
                    // fill_count stays at 8 and taps hold for the whole sweep
                    if (sel_ready) begin
                        if (r_sel == c_LAST_SEL) begin
                            r_state      <= ST_FILL;
                            r_fill_count <= 4'd0;
                            r_sel        <= 3'd0;
                            r_sel_valid  <= 1'b0;
                            r_in_ready   <= 1'b1;
                            r_win_done   <= 1'b1;
                        end else begin
                            r_sel <= r_sel + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    assign tap0       = r_tap[0];
    assign tap1       = r_tap[1];
    assign tap2       = r_tap[2];
    assign tap3       = r_tap[3];
    assign tap4       = r_tap[4];
    assign tap5       = r_tap[5];
    assign tap6       = r_tap[6];
    assign tap7       = r_tap[7];
    assign sel        = r_sel;
    assign sel_valid  = r_sel_valid;
    assign in_ready   = r_in_ready;
    assign win_done   = r_win_done;
    assign fill_count = r_fill_count;

endmodule
`default_nettype wire

// File: tb/tb_window_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_window_loader
//  Description : Directed self-checking bench for window_loader. Stored bytes
//                are queued when driven and popped as the sweep presents them.
//                Expected storage honours WINDOW_LOADER_RELU_EN if defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_window_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] tap0, tap1, tap2, tap3, tap4, tap5, tap6, tap7;
    logic [2:0] sel;
    logic       sel_valid;
    logic       sel_ready;
    logic       win_done;
    logic [3:0] fill_count;

    logic [7:0] tp [8];
    logic [7:0] exp_tap [8];
    logic [7:0] pat [8];
    logic [7:0] sb_q [$];
    int         n_vec = 0;
    int         n_err = 0;

    window_loader #(.DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .tap0       (tap0),
        .tap1       (tap1),
        .tap2       (tap2),
        .tap3       (tap3),
        .tap4       (tap4),
        .tap5       (tap5),
        .tap6       (tap6),
        .tap7       (tap7),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .win_done   (win_done),
        .fill_count (fill_count)
    );

    always #5 clk = ~clk;

    assign tp[0] = tap0;
    assign tp[1] = tap1;
    assign tp[2] = tap2;
    assign tp[3] = tap3;
    assign tp[4] = tap4;
    assign tp[5] = tap5;
    assign tp[6] = tap6;
    assign tp[7] = tap7;

    function automatic logic [7:0] stored(input logic [7:0] d);
`ifdef WINDOW_LOADER_RELU_EN
        return d[7] ? 8'h00 : d;
`else
        return d;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_taps(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s tap%0d", tag, i), {24'd0, tp[i]}, {24'd0, exp_tap[i]});
        end
    endtask

    task automatic set_pat(input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            pat[i] = base + 8'(i);
        end
    endtask

    // Drive the first n bytes of pat with in_valid held high
    task automatic feed(input int n);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            check("fill in_ready", {31'd0, in_ready}, 32'd1);
            check("fill sel_valid", {31'd0, sel_valid}, 32'd0);
            check("fill count", {28'd0, fill_count}, i);
            in_valid = 1'b1;
            in_data  = pat[i];
            v = stored(pat[i]);
            exp_tap[i] = v;
            sb_q.push_back(v);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Sweep a full window; optional stall at one index and flush on the last handshake
    task automatic sweep(input int stall_at, input int stall_n, input bit collide);
        logic [7:0] e;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int k = 0; k < 8; k++) begin
            if (k == stall_at) begin
                sel_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    check("stall sel", {29'd0, sel}, k);
                    check("stall sel_valid", {31'd0, sel_valid}, 32'd1);
                end
            end
            sel_ready = 1'b1;
            check("sweep sel_valid", {31'd0, sel_valid}, 32'd1);
            check("sweep sel", {29'd0, sel}, k);
            check("sweep in_ready", {31'd0, in_ready}, 32'd0);
            check("sweep fill_count", {28'd0, fill_count}, 32'd8);
            check("sweep win_done", {31'd0, win_done}, 32'd0);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hXX;
            check("sweep byte", {24'd0, tp[sel]}, {24'd0, e});
            if (k == 7 && collide) flush = 1'b1;
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        check("end win_done", {31'd0, win_done}, collide ? 32'd0 : 32'd1);
        check("end in_ready", {31'd0, in_ready}, 32'd1);
        check("end sel_valid", {31'd0, sel_valid}, 32'd0);
        check("end sel", {29'd0, sel}, 32'd0);
        check("end fill_count", {28'd0, fill_count}, 32'd0);
        check_taps("end");
        tick();
        check("win_done pulse", {31'd0, win_done}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        flush     = 1'b0;
        sel_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_tap[i] = 8'h00;

        // Reset held two cycles
        tick();
        tick();
        rst = 1'b0;
        check_taps("reset");
        check("reset sel", {29'd0, sel}, 32'd0);
        check("reset sel_valid", {31'd0, sel_valid}, 32'd0);
        check("reset fill_count", {28'd0, fill_count}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset win_done", {31'd0, win_done}, 32'd0);

        // Basic window
        set_pat(8'h10);
        feed(8);
        sweep(99, 0, 1'b0);

        // Backpressure at sel=4, in_valid asserted during sweep is ignored
        set_pat(8'h20);
        feed(8);
        sweep(4, 3, 1'b0);

        // Flush at fill_count=5 alongside an input byte that must be dropped
        set_pat(8'h30);
        feed(5);
        check("pre-flush fill_count", {28'd0, fill_count}, 32'd5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        check("flush fill_count", {28'd0, fill_count}, 32'd0);
        check("flush in_ready", {31'd0, in_ready}, 32'd1);
        check("flush sel_valid", {31'd0, sel_valid}, 32'd0);
        check("flush win_done", {31'd0, win_done}, 32'd0);
        check_taps("flush");
        set_pat(8'h40);
        feed(8);
        sweep(99, 0, 1'b0);

        // Flush colliding with the final sel handshake
        set_pat(8'h50);
        feed(8);
        sweep(99, 0, 1'b1);

        // Negative-byte handling
        pat[0] = 8'h80; pat[1] = 8'hFF; pat[2] = 8'h7F; pat[3] = 8'h00;
        pat[4] = 8'h01; pat[5] = 8'h02; pat[6] = 8'h03; pat[7] = 8'h04;
        feed(8);
        check_taps("relu");
        sweep(99, 0, 1'b0);

        // Reset mid-sweep overrides a simultaneous flush and handshake
        set_pat(8'h60);
        feed(8);
        sel_ready = 1'b1;
        tick();
        tick();
        tick();
        check("mid sel", {29'd0, sel}, 32'd3);
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 8; i++) exp_tap[i] = 8'h00;
        check_taps("mid reset");
        check("mid reset sel", {29'd0, sel}, 32'd0);
        check("mid reset sel_valid", {31'd0, sel_valid}, 32'd0);
        check("mid reset in_ready", {31'd0, in_ready}, 32'd1);
        check("mid reset fill_count", {28'd0, fill_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/window_loader.md
WINDOW_LOADER -- requirements
Module: window_loader

Interface
REQ-001 The block SHALL have a single clock domain; reset is synchronous and active-high.
REQ-002 Parameter: DW, default 8, width of each pixel byte; the block SHALL support only DW=8 so it matches the downstream 8:1 byte selector.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: in_data  input  DW  serial pixel byte.
REQ-006 Port: in_valid  input  1  in_data is valid this cycle.
REQ-007 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-008 Port: flush  input  1  abandon the current window and return to FILL.
REQ-009 Port: tap0..tap7  output  DW each  registered window bytes, wired to selector inputs in0..in7.
REQ-010 Port: sel  output  3  selector index driven to the downstream byte selector.
REQ-011 Port: sel_valid  output  1  sel and taps are stable and the selected byte is valid.
REQ-012 Port: sel_ready  input  1  downstream consumed the selected byte.
REQ-013 Port: win_done  output  1  one-cycle pulse after the last byte of a window is consumed.
REQ-014 Port: fill_count  output  4  number of bytes captured in the current window, 0..8.

Function
REQ-015 States SHALL be FILL and SWEEP only.
REQ-016 FILL behaviour:
- in_ready=1 and sel_valid=0.
- On in_valid&&in_ready, in_data is written to tap[fill_count] and fill_count increments.
REQ-017 When the 8th byte is accepted (fill_count 7->8), the next state SHALL be SWEEP with sel=0; in_ready SHALL be 0 in that same cycle's successor.
REQ-018 SWEEP behaviour:
- in_ready=0 and sel_valid=1.
- Taps SHALL hold constant.
- fill_count SHALL read 8.
REQ-019 In SWEEP, on sel_valid&&sel_ready with sel<7, sel SHALL increment by 1 the next cycle.
REQ-020 In SWEEP, when sel_ready is low, sel SHALL hold.
REQ-021 On sel_valid&&sel_ready with sel==7:
- next cycle: win_done=1, state=FILL, fill_count=0, sel=0;
- taps retain their values until overwritten.
REQ-022 Latency from the 8th accepted byte to the first sel_valid SHALL be exactly 1 cycle.
REQ-023 Throughput SHALL be 8 fill cycles plus 8 sweep cycles per window when in_valid and sel_ready are held high; there is no overlap of fill and sweep.
REQ-024 flush=1 in any state SHALL, next cycle:
- set state=FILL, fill_count=0, sel=0, sel_valid=0, win_done=0;
- leave taps unchanged.
REQ-025 flush SHALL take priority over a simultaneous input handshake or sel handshake; that byte is dropped.
REQ-026 in_valid in SWEEP SHALL be ignored; no tap write occurs.
REQ-027 sel SHALL never exceed 7; sel_valid SHALL never be 1 in FILL.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL set:
- state=FILL, fill_count=0, sel=0, sel_valid=0, win_done=0;
- tap0..tap7=0;
- in_ready=1 from the first cycle after reset release.
REQ-029 rst SHALL override flush and all handshakes, including mid-SWEEP, where the partial window is discarded.

Configuration
REQ-030 Macro WINDOW_LOADER_RELU_EN, when defined, SHALL store bytes with in_data[7]==1 (negative, two's complement) as 8'h00 and all other bytes unchanged.
REQ-031 Without WINDOW_LOADER_RELU_EN, bytes SHALL be stored verbatim.
REQ-032 The macro SHALL NOT change timing.

Verification
REQ-033 Reset: assert rst for 2 cycles, then release -> all taps=0, sel=0, sel_valid=0, fill_count=0, in_ready=1.
REQ-034 Basic window: stream 0x10..0x17 with sel_ready=1 -> sel steps 0..7 on consecutive cycles, taps=0x10..0x17, win_done pulses once, in_ready returns to 1.
REQ-035 Backpressure: hold sel_ready=0 for 3 cycles at sel=4 -> sel stays 4 and sel_valid stays 1, then the sweep resumes at 5.
REQ-036 Flush: assert flush at fill_count=5, then stream 8 new bytes -> fill_count restarts at 0, only the new bytes sweep, no win_done for the flushed window.
REQ-037 Collision: flush together with sel handshake at sel=7 -> no win_done, state=FILL next cycle.
REQ-038 RELU: feed 0x80, 0xFF, 0x7F, 0x00 in the first four slots -> with the macro, taps=0,0,0x7F,0; without it, taps=0x80,0xFF,0x7F,0x00.
